riscv_mdu: RTL
==============

# riscv_mdu

Iterative multiply/divide unit for the RV32M extension in the Execute stage of the pipelined core. It accepts one M-type operation from the decoded Execute-stage control and runs a 32-step shift-add multiply or restoring divide. While it works it stalls the Fetch, Decode and Execute registers, then presents the result for one cycle so the Execute/Memory register can capture it. A flush of Execute aborts an operation in progress.

## Interface

- XLEN, 32, operand/result width; iteration count equals XLEN
- iclk  in  1  clock; all state changes on the rising edge
- irst  in  1  reset, synchronous, active-high
- iflush_e  in  1  Execute flush; aborts any operation
- istart  in  1  an M-type instruction is in Execute (op=0110011, funct7=0000001)
- ifunct3  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- ia  in  XLEN  rs1 operand (post-forwarding)
- ib  in  XLEN  rs2 operand (post-forwarding)
- ostall  out  1  hold Fetch/Decode/Execute registers
- odone  out  1  oresult valid, one-cycle pulse
- oresult  out  XLEN  registered result

## Operation

- FSM states: IDLE, RUN, FIX, DONE.
- IDLE
  - istart=1 accepts the operation at edge T0.
  - At T0 the unit latches funct3, the operand magnitudes and the sign flags, and clears the 6-bit counter.
  - Next state is RUN, or DONE for special cases.
- Signedness
  - MULH: both operands signed.
  - MULHSU: ia signed, ib unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
  - DIV, REM: both operands signed.
  - MUL uses the low word, so signedness is irrelevant.
- RUN
  - One multiply or divide step per cycle on a 2·XLEN accumulator. The counter increments each step.
  - The FSM leaves RUN on the edge where the counter reaches XLEN−1, after 32 steps, and goes to FIX.
- FIX
  - Applies sign correction by two's-complement negation of the magnitude result.
    - Product sign is sa^sb.
    - Quotient sign is sa^sb.
    - Remainder sign is sa.
  - Selects the word: MUL takes the low word, MULH/MULHSU/MULHU take the high word.
  - Registers oresult. Next state is DONE.
- DONE
  - odone=1 for exactly one cycle; next state is IDLE.
  - istart is ignored in DONE, because the same instruction is still in Execute.
- Special cases, decided at T0, go directly to DONE:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF. REM/REMU give ia.
  - Signed overflow (ia=0x80000000, ib=0xFFFFFFFF): DIV gives 0x80000000. REM gives 0.
- ostall = (IDLE & istart & ~iflush_e) | RUN | FIX. It is 0 in DONE, so the pipeline advances at the end of DONE.
- oresult holds its value until the next FIX or special-case load.
- Reset and flush
  - irst or iflush_e forces IDLE and drops odone at the next edge, overriding any other transition.
  - On irst only, oresult is also cleared.
  - Reset values: state IDLE, odone 0, oresult 0, counter 0. ostall is 0 whenever istart=0.

## Timing

- Normal operation
  - Accept at T0; RUN spans T1..T32; FIX at T33.
  - odone is high in the cycle between T33 and T34.
  - ostall is high for 34 cycles: the start cycle plus cycles T0..T33.
- Special case: odone is high in the cycle after T0, with 1 stall cycle.
- istart arriving in the IDLE cycle right after DONE is accepted normally, giving back-to-back operations.
- ia/ib are sampled only at T0; later changes have no effect.
- Flush at T0 with istart=1: nothing is accepted and ostall=0 in that cycle.
- Flush during RUN or FIX: ostall drops in the following cycle and odone is never asserted.

## Structure

- riscv_mdu_pkg
  - Funct3 encodings and the FSM state enum.
  - XLEN default.
  - Special-case constants: all-ones, 0x80000000.
- Sub-module riscv_mdu_iter holds the accumulator, the shift-add and trial-subtract step logic, and the counter.
- The top level keeps the FSM, special-case detection, sign correction and the oresult register.

## Test plan

- MUL 7 × 0xFFFFFFFD → oresult 0xFFFFFFEB; odone in the cycle after T33; ostall high for 34 cycles.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
- REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
- DIVU 0x64 / 7 → 0xE.
- REMU 0x64 / 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF, odone one cycle after T0.
- REM 5 / 0 → 5.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, 1 stall cycle.
- iflush_e at T10 → IDLE next cycle; ostall 0 from then; no odone pulse.
- irst at T10 → IDLE, oresult 0.
- Back-to-back MUL then DIVU: the second op is accepted in the IDLE cycle after DONE, and both results are correct.

Source files
------------

// File: rtl/riscv_mdu_pkg.sv
// riscv_mdu_pkg: shared constants, funct3 encodings and FSM state type for
// the RV32M iterative multiply/divide unit.
package riscv_mdu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] SIGN_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // rs1 is treated as signed
    function automatic logic op_signed_a(input funct3_e f);
        return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
    endfunction

    // rs2 is treated as signed
    function automatic logic op_signed_b(input funct3_e f);
        return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
    endfunction

endpackage

// File: rtl/riscv_mdu_iter.sv
// riscv_mdu_iter: 2*XLEN accumulator datapath for the iterative MDU.
//   iclk, irst      clock, synchronous active-high reset
//   iload           capture operand magnitudes and mode, clear the counter
//   istep           perform one shift-add (mul) or restoring-divide step
//   idiv            operation class at load: 1 = divide, 0 = multiply
//   ia_mag, ib_mag  unsigned operand magnitudes
//   oacc            accumulator: mul -> {hi, lo} product; div -> {rem, quot}
//   olast           counter is at XLEN-1 (current step is the last one)
module riscv_mdu_iter
    import riscv_mdu_pkg::*;
(
    input  logic              iclk,
    input  logic              irst,
    input  logic              iload,
    input  logic              istep,
    input  logic              idiv,
    input  logic [XLEN-1:0]   ia_mag,
    input  logic [XLEN-1:0]   ib_mag,
    output logic [2*XLEN-1:0] oacc,
    output logic              olast
);

    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_nxt;
    logic [XLEN-1:0]   opnd;
    logic [CNT_W-1:0]  cnt;
    logic              div_q;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   rem_sub;
    logic              rem_ge;

    // Next accumulator value for one step of the latched operation
    always_comb begin
        add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
        // Partial remainder after the left shift; can need XLEN+1 bits
        rem_sh  = acc[2*XLEN-1:XLEN-1];
        rem_ge  = (rem_sh >= {1'b0, opnd});
        // Difference is below the divisor when taken, so XLEN bits suffice
        rem_sub = rem_sh[XLEN-1:0] - opnd;
        acc_nxt = acc;
        if (div_q) begin
            if (rem_ge) acc_nxt = {rem_sub, acc[XLEN-2:0], 1'b1};
            else        acc_nxt = {acc[2*XLEN-2:0], 1'b0};
        end else begin
            if (acc[0]) acc_nxt = {add_sum, acc[XLEN-1:1]};
            else        acc_nxt = {1'b0, acc[2*XLEN-1:1]};
        end
    end

    // Multiplier (mul) or dividend (div) starts in the low word
    always_ff @(posedge iclk) begin
        if (irst) begin
            acc   <= '0;
            opnd  <= '0;
            cnt   <= '0;
            div_q <= 1'b0;
        end else if (iload) begin
            acc   <= {XLEN'(0), (idiv ? ia_mag : ib_mag)};
            opnd  <= idiv ? ib_mag : ia_mag;
            cnt   <= '0;
            div_q <= idiv;
        end else if (istep) begin
            acc   <= acc_nxt;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    assign oacc  = acc;
    assign olast = (cnt == CNT_W'(XLEN-1));

endmodule

// File: rtl/riscv_mdu.sv
// riscv_mdu: RV32M iterative multiply/divide unit for the Execute stage.
//   iclk, irst   clock, synchronous active-high reset
//   iflush_e     Execute flush, aborts any operation
//   istart       M-type instruction present in Execute
//   ifunct3      operation select (MUL..REMU)
//   ia, ib       rs1 / rs2 operands, sampled only at acceptance
//   ostall       hold Fetch/Decode/Execute while the unit is busy
//   odone        one-cycle pulse, oresult valid
//   oresult      registered result, held until the next load
module riscv_mdu
    import riscv_mdu_pkg::*;
(
    input  logic            iclk,
    input  logic            irst,
    input  logic            iflush_e,
    input  logic            istart,
    input  logic [2:0]      ifunct3,
    input  logic [XLEN-1:0] ia,
    input  logic [XLEN-1:0] ib,
    output logic            ostall,
    output logic            odone,
    output logic [XLEN-1:0] oresult
);

    state_e            state;
    funct3_e           f3_in;
    funct3_e           f3_q;
    logic              neg_q;
    logic              rneg_q;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              special;
    logic [XLEN-1:0]   special_val;
    logic              accept;
    logic [2*XLEN-1:0] acc;
    logic              last;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   fixed;

    assign f3_in  = funct3_e'(ifunct3);
    assign accept = (state == IDLE) && istart && !iflush_e;
    assign ostall = accept || (state == RUN) || (state == FIX);

    // Operand magnitudes and the cases that bypass the iteration
    always_comb begin
        a_neg       = op_signed_a(f3_in) && ia[XLEN-1];
        b_neg       = op_signed_b(f3_in) && ib[XLEN-1];
        a_mag       = a_neg ? -ia : ia;
        b_mag       = b_neg ? -ib : ib;
        special     = 1'b0;
        special_val = '0;
        // ifunct3[2]: divide class, [1]: remainder, [0]: unsigned
        if (ifunct3[2]) begin
            if (ib == '0) begin
                special     = 1'b1;
                special_val = ifunct3[1] ? ia : ALL_ONES;
            end else if (!ifunct3[0] && (ia == SIGN_MIN) && (ib == ALL_ONES)) begin
                special     = 1'b1;
                special_val = ifunct3[1] ? '0 : SIGN_MIN;
            end
        end
    end

    riscv_mdu_iter u_iter (
        .iclk   (iclk),
        .irst   (irst),
        .iload  (accept && !special),
        .istep  (state == RUN),
        .idiv   (ifunct3[2]),
        .ia_mag (a_mag),
        .ib_mag (b_mag),
        .oacc   (acc),
        .olast  (last)
    );

    // Sign correction and word selection of the finished accumulator
    always_comb begin
        prod  = neg_q ? -acc : acc;
        fixed = '0;
        case (f3_q)
            F3_MUL:                        fixed = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fixed = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               fixed = neg_q  ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            F3_REM, F3_REMU:               fixed = rneg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
            default:                       fixed = '0;
        endcase
    end

    // Control FSM; reset and flush override every transition
    always_ff @(posedge iclk) begin
        if (irst) begin
            state   <= IDLE;
            odone   <= 1'b0;
            oresult <= '0;
            f3_q    <= F3_MUL;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
        end else if (iflush_e) begin
            state <= IDLE;
            odone <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    odone <= 1'b0;
                    if (istart) begin
                        f3_q   <= f3_in;
                        neg_q  <= a_neg ^ b_neg;
                        rneg_q <= a_neg;
                        if (special) begin
                            oresult <= special_val;
                            odone   <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (last) state <= FIX;
                end
                FIX: begin
                    oresult <= fixed;
                    odone   <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    // istart still reflects the finished instruction here
                    odone <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    odone <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
